// File: rtl/psum_requant_buffer.sv
// rtl/psum_requant_buffer.sv - partial-sum requantizer with output FIFO
//
// Captures a signed partial sum on each PE done pulse. It then applies a
// round-half-up arithmetic right shift, an optional ReLU and signed
// saturation to OUT_W bits. Results are queued in a DEPTH-entry FIFO
// that drains through a valid/ready interface.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   psum_in, psum_valid   partial sum and its done pulse (sampled together)
//   shift_amt, relu_en    per-sample requant controls
//   out_data, out_valid   FIFO head (0 when empty) and non-empty flag
//   out_ready             consumer pop strobe
//   full, count           FIFO status
//   overflow_err          sticky: a result was dropped because the FIFO was full
module psum_requant_buffer #(
  parameter int PSUM_W = 32,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  input  logic [4:0]        shift_amt,
  input  logic              relu_en,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err
);

  localparam int EXT_W = PSUM_W + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

  // Stage 1: capture registers
  logic [PSUM_W-1:0] s1_psum_q;
  logic [4:0]        s1_shift_q;
  logic              s1_relu_q;
  logic              s1_valid_q;

  // Stage 2: requantized result
  logic [OUT_W-1:0]  s2_data_q, s2_data_d;
  logic              s2_valid_q;

  // FIFO state
  logic [OUT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  logic signed [EXT_W-1:0] ext, rnd, sum, shifted;
  logic empty, pop, push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_psum_q  <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= psum_valid;
      if (psum_valid) begin
        s1_psum_q  <= psum_in;
        s1_shift_q <= shift_amt;
        s1_relu_q  <= relu_en;
      end
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping at the
  // positive extreme of the partial-sum range.
  always_comb begin
    ext = signed'({s1_psum_q[PSUM_W-1], s1_psum_q});
    rnd = '0;
    if (s1_shift_q != 5'd0) begin
      rnd = EXT_W'(1) << (s1_shift_q - 5'd1);
    end
    sum     = ext + rnd;
    shifted = sum >>> s1_shift_q;
    if (s1_relu_q && shifted < 0) begin
      shifted = '0;
    end
    if (shifted > SAT_MAX) begin
      s2_data_d = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      s2_data_d = SAT_MIN[OUT_W-1:0];
    end else begin
      s2_data_d = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
      end
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push  = s2_valid_q && (!full || pop);
  assign drop  = s2_valid_q && full && !pop;

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: doc/psum_requant_buffer.md
Name: psum_requant_buffer

Overview:
- Downstream stage of the PE.
- Captures each 32-bit partial sum that the PE presents with its done pulse.
- Applies rounding right-shift, optional ReLU and signed saturation to 8 bits.
- Queues results in a small FIFO with a valid/ready output, so the next layer or feature-map writer can drain at its own pace.

Parameters:
- PSUM_W, 32, width of incoming signed partial sum
- OUT_W, 8, width of requantized signed output
- DEPTH, 4, FIFO entries (power of two, >=2)
- CNT_W, 3, width of occupancy count; must hold DEPTH

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- psum_in  in  PSUM_W  signed partial sum from PE
- psum_valid  in  1  PE done pulse; psum_in is sampled when high
- shift_amt  in  5  right-shift amount, sampled together with psum_in
- relu_en  in  1  clamp negatives to 0, sampled together with psum_in
- out_data  out  OUT_W  head-of-FIFO value
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid&&out_ready
- full  out  1  count==DEPTH
- count  out  CNT_W  FIFO occupancy
- overflow_err  out  1  sticky: a result was dropped

Behaviour:
Reset:
- rst high clears all state immediately, not waiting for a clock edge.
- Outputs during reset: out_data=0, out_valid=0, full=0, count=0, overflow_err=0.
- The stage1/stage2 valids and the FIFO pointers are also cleared.
- Asserting rst mid-operation discards all pipeline and FIFO contents.

Stage 1 (capture register):
- On a clk edge with psum_valid=1, register psum_in, shift_amt and relu_en, and set s1_valid=1.
- Otherwise s1_valid=0.
- Back-to-back psum_valid pulses are accepted every cycle.

Stage 2 (arithmetic, registered):
- Sign-extend psum to PSUM_W+1 bits.
- If shift_amt>0, add 1<<(shift_amt-1) (round half up).
- Arithmetic right shift by shift_amt.
- If relu_en and the result is <0, the result is 0.
- Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128,127].
- Register the result with s2_valid.

FIFO write:
- When s2_valid=1 and the FIFO is not full, write at wr_ptr and increment wr_ptr.
- If full with a simultaneous pop, the write is still accepted and count is unchanged.
- If full with no pop, the result is dropped and overflow_err is set to 1. It is cleared only by rst.

FIFO read:
- When out_valid&&out_ready, rd_ptr is incremented.
- out_data is combinational from mem[rd_ptr] and is 0 when empty.
- A pop with out_valid=0 is ignored.

Pointers and count:
- Pointers wrap modulo DEPTH.
- count: +1 on write only, -1 on pop only, unchanged on both or neither.

Latency:
- psum_valid sampled at edge N gives out_valid=1 after edge N+2 when the FIFO is empty.
- Ordering is strictly FIFO. There is no backpressure to the PE.

Test Plan:
- Basic path: psum_in=0x00000500, shift_amt=4, relu_en=0, out_ready=1 -> out_data=0x50, out_valid high 2 cycles after the sample edge, count returns to 0.
- Negative value: psum_in=0xFFFFFED4 (-300), shift_amt=2, relu_en=0 -> out_data=0xB5 (-75). Repeat with relu_en=1 -> out_data=0x00.
- Saturation: psum_in=0x00010000, shift_amt=0 -> 0x7F. psum_in=0xFFFF0000, shift_amt=0 -> 0x80.
- Overflow:
  - Stimulus: out_ready=0, five consecutive psum_valid pulses with values 1..5 at shift 0.
  - During the pulses: count=4, full=1, overflow_err=1.
  - Then out_ready=1: outputs in order 0x01..0x04, 5 absent, overflow_err remains 1.
- Simultaneous push/pop when full: fill 4 entries, then one pulse with out_ready=1 aligned to the stage-2 write -> count stays 4, full stays 1, no overflow, new value appears last.
- Reset mid-operation: two entries queued, raise rst between clock edges -> out_valid=0, count=0, overflow_err=0 immediately. After release, the next pulse behaves as in the basic-path scenario.
